// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue unit: ALU control codes, R-type funct values,
// FSM state encoding and the instruction decoder.
package alu_pkg;

  localparam logic [1:0] CTRL_ADD = 2'b00;
  localparam logic [1:0] CTRL_SUB = 2'b01;
  localparam logic [1:0] CTRL_OR  = 2'b10;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_OR  = 6'h25;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  typedef struct packed {
    logic       legal;
    logic [1:0] ctrl;
  } decode_t;

  // Only op=0 with add/sub/or funct is legal; shamt and the rest are don't-care.
  function automatic decode_t decode(input logic [31:0] word);
    decode_t d;
    d.legal = 1'b0;
    d.ctrl  = CTRL_ADD;
    if (word[31:26] == 6'd0) begin
      case (word[5:0])
        FUNCT_ADD: begin d.legal = 1'b1; d.ctrl = CTRL_ADD; end
        FUNCT_SUB: begin d.legal = 1'b1; d.ctrl = CTRL_SUB; end
        FUNCT_OR:  begin d.legal = 1'b1; d.ctrl = CTRL_OR;  end
        default:   d.legal = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two operand read ports, one write port, one debug read port.
// R0 is hard-wired to zero and never stored.
module reg_file (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra_a,
  input  logic [4:0]  ra_b,
  output logic [31:0] rd_a,
  output logic [31:0] rd_b,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_rdata
);

  logic [31:0] regs [1:31];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd_a      = (ra_a == 5'd0)     ? '0 : regs[ra_a];
  assign rd_b      = (ra_b == 5'd0)     ? '0 : regs[ra_b];
  assign dbg_rdata = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// Issues MIPS R-type add/sub/or to an external ALU, waits ALU_LAT+1 cycles,
// captures the result and writes it back unless the ALU reports overflow.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [31:0] ALU_DA,
  output logic [31:0] ALU_DB,
  output logic [1:0]  ALU_Ctrl,
  input  logic [31:0] ALU_DC,
  input  logic        ALU_ZERO,
  input  logic        ALU_OverFlow,
  output logic        done,
  output logic [31:0] result,
  output logic        zero_flag,
  output logic        ovf_flag,
  output logic        illegal,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata
);

  localparam int CW = $clog2(ALU_LAT + 2);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [4:0]    rd_q;
  logic [31:0]   rs_val, rt_val;
  decode_t       dec;
  logic          accept, exec_last, wb_we, dbg_ok;
  logic          rf_we;
  logic [4:0]    rf_wa;
  logic [31:0]   rf_wd;

  assign dec         = decode(instr);
  assign instr_ready = rst_n && (state == ST_IDLE);
  assign accept      = instr_valid && instr_ready;
  assign done        = (state == ST_WB);
  assign exec_last   = (state == ST_EXEC) && (cnt == CW'(ALU_LAT));

  // Write-back and debug writes never coincide: debug only lands in IDLE without an accept.
  assign wb_we  = exec_last && !ALU_OverFlow;
  assign dbg_ok = dbg_we && rst_n && (state == ST_IDLE) && !accept;
  assign rf_we  = wb_we || dbg_ok;
  assign rf_wa  = wb_we ? rd_q   : dbg_addr;
  assign rf_wd  = wb_we ? ALU_DC : dbg_wdata;

  reg_file u_reg_file (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra_a      (instr[25:21]),
    .ra_b      (instr[20:16]),
    .rd_a      (rs_val),
    .rd_b      (rt_val),
    .we        (rf_we),
    .wa        (rf_wa),
    .wd        (rf_wd),
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rd_q      <= '0;
      ALU_DA    <= '0;
      ALU_DB    <= '0;
      ALU_Ctrl  <= CTRL_ADD;
      result    <= '0;
      zero_flag <= 1'b0;
      ovf_flag  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (dec.legal) begin
              ALU_DA   <= rs_val;
              ALU_DB   <= rt_val;
              ALU_Ctrl <= dec.ctrl;
              rd_q     <= instr[15:11];
              cnt      <= '0;
              state    <= ST_EXEC;
            end else begin
              illegal <= 1'b1;
              state   <= ST_WB;
            end
          end
        end
        ST_EXEC: begin
          if (exec_last) begin
            result    <= ALU_DC;
            zero_flag <= ALU_ZERO;
            illegal   <= 1'b0;
            if (ALU_OverFlow) ovf_flag <= 1'b1;
            state     <= ST_WB;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_WB:   state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit: external ALU model with ALU_LAT latency,
// directed vector table, hand-written reset/collision sequences and random traffic.
module tb_alu_issue_unit;

  localparam int ALU_LAT = 1;
  localparam int HI      = (ALU_LAT > 0) ? ALU_LAT - 1 : 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] ALU_DA, ALU_DB;
  logic [1:0]  ALU_Ctrl;
  logic [31:0] ALU_DC;
  logic        ALU_ZERO, ALU_OverFlow;
  logic        done;
  logic [31:0] result;
  logic        zero_flag, ovf_flag, illegal;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_unit #(.ALU_LAT(ALU_LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_ready  (instr_ready),
    .ALU_DA       (ALU_DA),
    .ALU_DB       (ALU_DB),
    .ALU_Ctrl     (ALU_Ctrl),
    .ALU_DC       (ALU_DC),
    .ALU_ZERO     (ALU_ZERO),
    .ALU_OverFlow (ALU_OverFlow),
    .done         (done),
    .result       (result),
    .zero_flag    (zero_flag),
    .ovf_flag     (ovf_flag),
    .illegal      (illegal),
    .dbg_we       (dbg_we),
    .dbg_addr     (dbg_addr),
    .dbg_wdata    (dbg_wdata),
    .dbg_rdata    (dbg_rdata)
  );

  // Reference ALU in plain signed arithmetic; returns {overflow, zero, result}.
  function automatic logic [33:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] ctrl);
    longint sa, sb, s;
    logic [31:0] r;
    logic ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ov = 1'b0;
    if (ctrl == 2'b10) begin
      r = a | b;
    end else begin
      s  = (ctrl == 2'b00) ? sa + sb : sa - sb;
      ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      r  = s[31:0];
    end
    return {ov, (r == 32'd0), r};
  endfunction

  logic [33:0] alu_now;
  logic [33:0] alu_hist [0:HI];

  always_comb alu_now = ref_alu(ALU_DA, ALU_DB, ALU_Ctrl);

  always @(posedge clk) begin
    alu_hist[0] <= alu_now;
    for (int i = 1; i <= HI; i++) alu_hist[i] <= alu_hist[i-1];
  end

  assign {ALU_OverFlow, ALU_ZERO, ALU_DC} = (ALU_LAT == 0) ? alu_now : alu_hist[HI];

  // Behavioural model of the architectural state.
  logic [31:0] model_r [0:31];
  logic [31:0] model_da, model_db, model_result;
  logic [1:0]  model_ctrl;
  logic        model_zero, model_ovf, model_illegal;

  task automatic modelReset();
    for (int i = 0; i < 32; i++) model_r[i] = '0;
    model_da = '0; model_db = '0; model_ctrl = 2'b00;
    model_result = '0; model_zero = 1'b0; model_ovf = 1'b0; model_illegal = 1'b0;
  endtask

  function automatic logic [2:0] ref_decode(input logic [31:0] w);
    logic [5:0] op, fn;
    op = w[31:26];
    fn = w[5:0];
    if (op != 6'd0) return 3'b000;
    if (fn == 6'h20) return 3'b100;
    if (fn == 6'h22) return 3'b101;
    if (fn == 6'h25) return 3'b110;
    return 3'b000;
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic dbgWrite(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    dbg_we = 1'b1; dbg_addr = addr; dbg_wdata = data;
    @(posedge clk);
    #1 dbg_we = 1'b0;
    if (addr != 5'd0) model_r[addr] = data;
  endtask

  task automatic checkAllRegs();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1 checkOutput($sformatf("R%0d", i), dbg_rdata, model_r[i]);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"}, instr_ready, 1'b0);
    checkOutput({tag, "_done"}, done, 1'b0);
    checkOutput({tag, "_DA"}, ALU_DA, 32'd0);
    checkOutput({tag, "_DB"}, ALU_DB, 32'd0);
    checkOutput({tag, "_Ctrl"}, ALU_Ctrl, 2'b00);
    checkOutput({tag, "_result"}, result, 32'd0);
    checkOutput({tag, "_zero"}, zero_flag, 1'b0);
    checkOutput({tag, "_ovf"}, ovf_flag, 1'b0);
    checkOutput({tag, "_illegal"}, illegal, 1'b0);
  endtask

  // Issue one word, then follow it to its done pulse and check everything it touched.
  task automatic applyStimulus(input logic [31:0] word, input bit junk, input bit collide);
    logic [2:0]  d;
    logic [4:0]  rd;
    logic [33:0] r;
    int          n, cyc;
    d  = ref_decode(word);
    rd = word[15:11];
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = word;
    if (collide) begin
      dbg_we = 1'b1; dbg_addr = 5'd10; dbg_wdata = $urandom;
    end
    n = 0;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      checkOutput("accept_timeout", instr_ready, 1'b1);
      instr_valid = 1'b0;
      dbg_we = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    dbg_we = 1'b0;
    if (junk) instr = $urandom; else instr_valid = 1'b0;
    if (d[2]) begin
      model_da   = model_r[word[25:21]];
      model_db   = model_r[word[20:16]];
      model_ctrl = d[1:0];
    end
    @(negedge clk);
    cyc = 1;
    checkOutput("busy_ready", instr_ready, 1'b0);
    checkOutput("ALU_DA", ALU_DA, model_da);
    checkOutput("ALU_DB", ALU_DB, model_db);
    checkOutput("ALU_Ctrl", ALU_Ctrl, model_ctrl);
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("done_latency", cyc, d[2] ? ALU_LAT + 2 : 1);
    if (d[2]) begin
      r = ref_alu(model_da, model_db, model_ctrl);
      model_result  = r[31:0];
      model_zero    = r[32];
      model_illegal = 1'b0;
      if (r[33]) model_ovf = 1'b1;
      else if (rd != 5'd0) model_r[rd] = r[31:0];
    end else begin
      model_illegal = 1'b1;
    end
    checkOutput("result", result, model_result);
    checkOutput("zero_flag", zero_flag, model_zero);
    checkOutput("ovf_flag", ovf_flag, model_ovf);
    checkOutput("illegal", illegal, model_illegal);
    dbg_addr = rd;
    #1 checkOutput("rd_value", dbg_rdata, model_r[rd]);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    checkOutput("done_pulse_width", done, 1'b0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  funct;
    logic [4:0]  rd;
    logic [31:0] exp_result;
    logic        exp_zero;
    logic        exp_ovf;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{32'h10,       32'h20,       6'h20, 5'd3, 32'h30,       1'b0, 1'b0, 32'h30};
    vecs[1] = '{32'h30,       32'h30,       6'h22, 5'd4, 32'h0,        1'b1, 1'b0, 32'h0};
    vecs[2] = '{32'hFF00FF00, 32'h00FF00FF, 6'h25, 5'd5, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFF};
    vecs[3] = '{32'h7FFFFFFF, 32'h1,        6'h20, 5'd6, 32'h80000000, 1'b0, 1'b1, 32'h55};
    vecs[4] = '{32'h5,        32'h3,        6'h20, 5'd7, 32'h8,        1'b0, 1'b1, 32'h8};
    vecs[5] = '{32'h80000000, 32'h1,        6'h22, 5'd8, 32'h7FFFFFFF, 1'b0, 1'b1, 32'h0};
    vecs[6] = '{32'h1,        32'h2,        6'h20, 5'd0, 32'h3,        1'b0, 1'b1, 32'h0};

    rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
    dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    modelReset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetState("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", instr_ready, 1'b1);
    checkAllRegs();

    $display("[TB] directed vectors");
    dbgWrite(5'd6, 32'h55);
    for (int i = 0; i < 7; i++) begin
      dbgWrite(5'd1, vecs[i].a);
      dbgWrite(5'd2, vecs[i].b);
      applyStimulus(rtype(5'd1, 5'd2, vecs[i].rd, vecs[i].funct), 1'b0, 1'b0);
      checkOutput($sformatf("vec%0d_result", i), result, vecs[i].exp_result);
      checkOutput($sformatf("vec%0d_zero", i), zero_flag, vecs[i].exp_zero);
      checkOutput($sformatf("vec%0d_ovf", i), ovf_flag, vecs[i].exp_ovf);
      dbg_addr = vecs[i].rd;
      #1 checkOutput($sformatf("vec%0d_rd", i), dbg_rdata, vecs[i].exp_rd);
    end

    $display("[TB] illegal words");
    applyStimulus(rtype(5'd1, 5'd2, 5'd9, 6'h24), 1'b1, 1'b0);
    checkOutput("illegal_funct24", illegal, 1'b1);
    applyStimulus({6'd8, 5'd1, 5'd2, 5'd9, 5'd0, 6'h20}, 1'b0, 1'b0);
    checkAllRegs();

    $display("[TB] rs equals rt and debug collision");
    dbgWrite(5'd1, 32'h21);
    applyStimulus(rtype(5'd1, 5'd1, 5'd11, 6'h20), 1'b0, 1'b1);
    checkOutput("rs_eq_rt_result", result, 32'h42);
    dbg_addr = 5'd10;
    #1 checkOutput("collision_dropped", dbg_rdata, 32'd0);

    $display("[TB] reset during EXEC");
    dbgWrite(5'd1, 32'h7);
    dbgWrite(5'd2, 32'h9);
    @(negedge clk);
    instr_valid = 1'b1;
    instr = rtype(5'd1, 5'd2, 5'd12, 6'h20);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkResetState("mid_exec_reset");
    rst_n = 1'b1;
    modelReset();
    @(negedge clk);
    checkOutput("ready_after_mid_reset", instr_ready, 1'b1);
    checkOutput("done_after_mid_reset", done, 1'b0);
    checkAllRegs();

    $display("[TB] random traffic");
    for (int i = 1; i < 32; i++) dbgWrite(5'(i), $urandom);
    for (int i = 0; i < 40; i++) begin
      int kind;
      logic [5:0] fn;
      kind = $urandom_range(0, 9);
      case ($urandom_range(0, 2))
        0:       fn = 6'h20;
        1:       fn = 6'h22;
        default: fn = 6'h25;
      endcase
      if (kind == 0) applyStimulus($urandom, 1'b0, 1'b0);
      else if (kind == 1) dbgWrite(5'($urandom_range(0, 31)), $urandom);
      else applyStimulus(rtype(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                               5'($urandom_range(0, 31)), fn),
                         1'($urandom_range(0, 1)), 1'b0);
    end
    checkAllRegs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
